// File: rtl/state_pkg.sv
// Shared definitions for the state enable generator.
//   state_e       : FSM encoding (value 3 is illegal and recovers to IDLE)
//   STATE_DEF_DIV : divider value loaded at reset
package state_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam int unsigned STATE_DEF_DIV = 100;

endpackage

// File: rtl/state_en_div.sv
// Prescale counter, divider register and terminal-count compare.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset (cnt=0, div=DEF_DIV)
//   i_clr    : clear counter this edge; otherwise the counter advances
//   i_div_ld : load i_div into the divider register
//   i_div    : divide ratio (0 behaves as 1)
//   o_term   : counter has reached (or passed) div_eff-1
module state_en_div
    import state_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = STATE_DEF_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_div_ld,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_term
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] last_cnt;

    always_comb begin
        // div==0 is treated as 1, so the last count is 0 in both cases.
        last_cnt = (div_q == '0) ? '0 : div_q - DIV_W'(1);
        // >= keeps terminating if the divider shrinks below the current count.
        o_term   = (cnt_q >= last_cnt);
        cnt_d    = i_clr ? '0 : cnt_q + DIV_W'(1);
        div_d    = i_div_ld ? i_div : div_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            div_q <= DIV_W'(DEF_DIV);
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/state_en_gen.sv
// Enable generator pacing the 4-bit state sequencer.
//   i_clk       : system clock
//   i_rst       : synchronous active-high reset
//   i_run       : level, free-run enables while high
//   i_step      : single-step request, sampled only in IDLE
//   i_div_ld    : load strobe for i_div
//   i_div       : divide ratio (0 behaves as 1)
//   o_en        : registered enable pulse to the sequencer
//   o_busy      : FSM not in IDLE
//   o_step_done : one-cycle pulse alongside the single-step enable
//   o_tick_cnt  : wrapping count of issued enables
module state_en_gen
    import state_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = STATE_DEF_DIV,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_div_ld,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_tick_cnt
);

    state_e           state_q;
    logic             en_q;
    logic             done_q;
    logic [CNT_W-1:0] tick_q;
    logic             term;
    logic             clr;

    state_en_div #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_div (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (clr),
        .i_div_ld (i_div_ld),
        .i_div    (i_div),
        .o_term   (term)
    );

    // Counter advances only while an active state keeps counting; a run drop
    // or terminal count restarts it, and IDLE holds it at zero.
    always_comb begin
        clr = 1'b1;
        case (state_q)
            ST_RUN:  clr = !i_run || term;
            ST_STEP: clr = term;
            default: clr = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= '0;
        end else begin
            en_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_run)       state_q <= ST_RUN;
                    else if (i_step) state_q <= ST_STEP;
                end
                ST_RUN: begin
                    if (!i_run) begin
                        state_q <= ST_IDLE;
                    end else if (term) begin
                        en_q   <= 1'b1;
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                ST_STEP: begin
                    if (term) begin
                        en_q    <= 1'b1;
                        done_q  <= 1'b1;
                        tick_q  <= tick_q + CNT_W'(1);
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_en        = en_q;
    assign o_step_done = done_q;
    assign o_tick_cnt  = tick_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_state_en_gen.sv
module tb_state_en_gen;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned DEF_DIV = 100;
    localparam int unsigned CNT_W   = 8;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_run = 1'b0;
    logic             i_step = 1'b0;
    logic             i_div_ld = 1'b0;
    logic [DIV_W-1:0] i_div = '0;
    logic             o_en;
    logic             o_busy;
    logic             o_step_done;
    logic [CNT_W-1:0] o_tick_cnt;

    state_en_gen #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_run       (i_run),
        .i_step      (i_step),
        .i_div_ld    (i_div_ld),
        .i_div       (i_div),
        .o_en        (o_en),
        .o_busy      (o_busy),
        .o_step_done (o_step_done),
        .o_tick_cnt  (o_tick_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic             en;
        logic             done;
        logic             busy;
        logic [CNT_W-1:0] tick;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // reference model state: 0=IDLE 1=RUN 2=STEP
    int unsigned      m_state = 0;
    logic [DIV_W-1:0] m_cnt = '0;
    logic [DIV_W-1:0] m_div = DIV_W'(DEF_DIV);
    logic [CNT_W-1:0] m_tick = '0;

    // observed-event counters used by directed checks
    int unsigned en_seen;
    int unsigned done_seen;
    int unsigned cyc_idx;
    int unsigned first_en_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, got, want);
    endtask

    // Drive one cycle of inputs, predict outputs after the edge, then compare.
    task automatic cyc(input logic rst, input logic run, input logic step,
                       input logic ld, input logic [DIV_W-1:0] div);
        exp_t             e;
        exp_t             got_e;
        logic [DIV_W-1:0] deff;
        logic             term;
        @(negedge i_clk);
        i_rst = rst; i_run = run; i_step = step; i_div_ld = ld; i_div = div;
        e.en = 1'b0; e.done = 1'b0;
        if (rst) begin
            m_state = 0; m_cnt = '0; m_div = DIV_W'(DEF_DIV); m_tick = '0;
        end else begin
            deff = (m_div == '0) ? DIV_W'(1) : m_div;
            term = (m_cnt >= deff - DIV_W'(1));
            case (m_state)
                1: if (!run) begin m_state = 0; m_cnt = '0; end
                   else if (term) begin m_cnt = '0; e.en = 1'b1; end
                   else m_cnt = m_cnt + DIV_W'(1);
                2: if (term) begin m_cnt = '0; e.en = 1'b1; e.done = 1'b1; m_state = 0; end
                   else m_cnt = m_cnt + DIV_W'(1);
                default: begin
                    m_cnt = '0;
                    if (run) m_state = 1;
                    else if (step) m_state = 2;
                end
            endcase
            if (ld) m_div = div;
            if (e.en) m_tick = m_tick + CNT_W'(1);
        end
        e.busy = (m_state != 0);
        e.tick = m_tick;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        got_e = exp_q.pop_front();
        chk("o_en", 32'(o_en), 32'(got_e.en));
        chk("o_step_done", 32'(o_step_done), 32'(got_e.done));
        chk("o_busy", 32'(o_busy), 32'(got_e.busy));
        chk("o_tick_cnt", 32'(o_tick_cnt), 32'(got_e.tick));
        cyc_idx++;
        if (o_en) begin
            en_seen++;
            if (first_en_idx == 0) first_en_idx = cyc_idx;
        end
        if (o_step_done) done_seen++;
    endtask

    task automatic clr_stats();
        en_seen = 0; done_seen = 0; cyc_idx = 0; first_en_idx = 0;
    endtask

    initial begin
        // 1: reset, then free-run at default divider
        cyc(1, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_tick", 32'(o_tick_cnt), 0);
        clr_stats();
        for (int i = 0; i < 301; i++) cyc(0, 1, 0, 0, '0);
        chk("t1_first_en_cycle", first_en_idx, 101);
        chk("t1_pulses", en_seen, 3);
        chk("t1_tick", 32'(o_tick_cnt), 3);
        chk("t1_busy", 32'(o_busy), 1);

        // 2: single step with div=4
        cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, 16'd4);
        clr_stats();
        cyc(0, 0, 1, 0, '0);
        for (int i = 0; i < 55; i++) cyc(0, 0, 0, 0, '0);
        chk("t2_first_en_cycle", first_en_idx, 5);
        chk("t2_pulses", en_seen, 1);
        chk("t2_done", done_seen, 1);

        // 3: div=0 then div=1, continuous enables and tick wrap
        cyc(0, 0, 0, 1, 16'd0);
        clr_stats();
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, '0);
        chk("t3_div0_pulses", en_seen, 10);
        cyc(0, 1, 0, 1, 16'd1);
        clr_stats();
        for (int i = 0; i < 260; i++) cyc(0, 1, 0, 0, '0);
        chk("t3_div1_pulses", en_seen, 260);

        // 4: div=10, shrink to 5 at cnt=7
        cyc(0, 0, 0, 1, 16'd10);
        clr_stats();
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, '0);
        cyc(0, 1, 0, 1, 16'd5);
        for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, '0);
        chk("t4_first_en_cycle", first_en_idx, 10);
        chk("t4_pulses", en_seen, 3);

        // 5: drop run on the terminal cycle, then run+step together
        cyc(0, 0, 0, 1, 16'd10);
        clr_stats();
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("t5_drop_busy", 32'(o_busy), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, '0);
        chk("t5_drop_pulses", en_seen, 0);
        clr_stats();
        cyc(0, 1, 1, 0, '0);
        for (int i = 0; i < 25; i++) cyc(0, 1, 0, 0, '0);
        cyc(0, 0, 0, 0, '0);
        chk("t5_both_done", done_seen, 0);
        chk("t5_both_pulses", en_seen, 2);

        // 6: reset mid-step, then confirm the default divider returned
        cyc(0, 0, 0, 1, 16'd8);
        cyc(0, 0, 1, 0, '0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, '0);
        cyc(1, 0, 0, 0, '0);
        chk("t6_rst_busy", 32'(o_busy), 0);
        chk("t6_rst_tick", 32'(o_tick_cnt), 0);
        clr_stats();
        for (int i = 0; i < 105; i++) cyc(0, 1, 0, 0, '0);
        chk("t6_default_div", first_en_idx, 101);

        // random mix of all inputs with small dividers
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                DIV_W'($urandom_range(0, 6)));

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
